// File: rtl/if_id_pipeline_ctrl.sv
// Fetch-side PC and IF/ID register control: holds on load-use stall, flushes on taken branch.
// Optional saturating performance counters are enabled with `define IF_ID_PERF_CNT_EN.
module if_id_pipeline_ctrl #(
   parameter int unsigned          PC_WIDTH  = 64,
   parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
   parameter int unsigned          CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 stall_i,
   input  logic                 branch_taken_i,
   input  logic [PC_WIDTH-1:0]  branch_target_i,
   input  logic [31:0]          instr_in_i,
   output logic [PC_WIDTH-1:0]  pc_out_o,
   output logic [PC_WIDTH-1:0]  if_id_pc_o,
   output logic [31:0]          if_id_instr_o,
   output logic                 if_id_valid_o,
   output logic                 id_ex_bubble_o,
   output logic                 id_ex_flush_o,
`ifdef IF_ID_PERF_CNT_EN
   output logic [CNT_WIDTH-1:0] stall_cycles_o,
   output logic [CNT_WIDTH-1:0] flush_count_o,
`endif
   output logic [1:0]           ctrl_state_o
);

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StStall = 2'd1,
      StFlush = 2'd2
   } state_e;

   localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(4);

   state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   if_id_pc_q, if_id_pc_d;
   logic [31:0]           if_id_instr_q, if_id_instr_d;
   logic                  if_id_valid_q, if_id_valid_d;

   // Next-state: branch beats stall beats normal advance; reset is applied in the register.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      if (branch_taken_i) begin
         state_d       = StFlush;
         pc_d          = branch_target_i;
         if_id_instr_d = '0;
         if_id_valid_d = 1'b0;
      end else if (stall_i) begin
         state_d = StStall;
      end else begin
         state_d       = StRun;
         pc_d          = pc_q + PcStep;
         if_id_pc_d    = pc_q;
         if_id_instr_d = instr_in_i;
         if_id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StRun;
         pc_q          <= RESET_PC;
         if_id_pc_q    <= '0;
         if_id_instr_q <= '0;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   always_comb begin
      pc_out_o       = pc_q;
      if_id_pc_o     = if_id_pc_q;
      if_id_instr_o  = if_id_instr_q;
      if_id_valid_o  = if_id_valid_q;
      ctrl_state_o   = state_q;
      id_ex_bubble_o = (stall_i | ~if_id_valid_q) & ~reset_i;
      id_ex_flush_o  = branch_taken_i & ~reset_i;
   end

`ifdef IF_ID_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
   logic                 stall_accept;

   // A stall coinciding with a branch is swallowed by the redirect and not counted.
   always_comb begin
      stall_accept   = stall_i & ~branch_taken_i;
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall_accept && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
      end
      if (branch_taken_i && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_count_o  = flush_count_q;
`else
   logic [CNT_WIDTH-1:0] unused_cnt_width;
   assign unused_cnt_width = '0;
`endif

endmodule
